// File: rtl/ycr_pipe_div_pkg.sv
// Shared types and helpers for the divider issue controller.
package ycr_pipe_div_pkg;

  localparam int DIV_W = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RDY,
    ST_REUSE,
    ST_RESP
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

  // Sign-tag the operand so the divider can treat both flavours as 33-bit signed.
  function automatic logic [DIV_W:0] encode_operand(input logic [DIV_W-1:0] src,
                                                    input logic             is_signed);
    return {is_signed & src[DIV_W-1], src};
  endfunction

endpackage

// File: rtl/ycr_pipe_div_ctrl.sv
// Issue-side controller for the iterative divider: request intake, divider
// handshake, quotient/remainder select, optional result reuse and flush.
module ycr_pipe_div_ctrl
  import ycr_pipe_div_pkg::*;
#(
  parameter bit REUSE_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [DIV_W-1:0]   req_src1,
  input  logic [DIV_W-1:0]   req_src2,
  input  logic               flush,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [DIV_W-1:0]   resp_data,
  output logic               div_data_valid,
  output logic [DIV_W:0]     div_din1,
  output logic [DIV_W:0]     div_din2,
  input  logic [DIV_W-1:0]   div_quotient,
  input  logic [DIV_W-1:0]   div_remainder,
  input  logic               div_rdy,
  output logic               div_data_done
);

  div_state_e       r_state, w_next_state;
  div_op_e          r_op;
  logic [DIV_W-1:0] r_src1, r_src2, r_quot, r_rem, r_resp_data;
  logic [DIV_W:0]   r_din1, r_din2;
  logic             r_signed, r_killed, r_reuse_vld, r_data_done;

  div_op_e w_req_op;
  logic    w_accept, w_reuse_hit, w_kill, w_div_done;

  assign w_req_op    = div_op_e'(req_op);
  assign w_accept    = (r_state == ST_IDLE) && req_valid && !flush;
  assign w_reuse_hit = REUSE_EN && r_reuse_vld && (req_src1 == r_src1) &&
                       (req_src2 == r_src2) && (op_is_signed(w_req_op) == r_signed);
  // A flush coinciding with div_rdy still kills the result.
  assign w_kill      = r_killed || flush;
  assign w_div_done  = (r_state == ST_WAIT_RDY) && div_rdy;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:     if (w_accept) w_next_state = w_reuse_hit ? ST_REUSE : ST_ISSUE;
      ST_ISSUE:    w_next_state = ST_WAIT_RDY;
      ST_WAIT_RDY: if (div_rdy) w_next_state = w_kill ? ST_IDLE : ST_RESP;
      ST_REUSE:    w_next_state = flush ? ST_IDLE : ST_RESP;
      ST_RESP:     if (flush || resp_ready) w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  // The start pulse is decoded from the single-cycle ISSUE state, so it can never be held.
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    div_data_valid = 1'b0;
    case (r_state)
      ST_IDLE:  req_ready      = !flush;
      ST_ISSUE: div_data_valid = 1'b1;
      ST_RESP:  resp_valid     = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= OP_DIV;
      r_src1      <= '0;
      r_src2      <= '0;
      r_signed    <= 1'b0;
      r_din1      <= '0;
      r_din2      <= '0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_resp_data <= '0;
      r_killed    <= 1'b0;
      r_reuse_vld <= 1'b0;
      r_data_done <= 1'b0;
    end else begin
      r_data_done <= w_div_done;
      if (w_accept) begin
        r_op     <= w_req_op;
        r_killed <= 1'b0;
        // Divider inputs only change here, so they stay put until div_data_done.
        if (!w_reuse_hit) begin
          r_src1      <= req_src1;
          r_src2      <= req_src2;
          r_signed    <= op_is_signed(w_req_op);
          r_din1      <= encode_operand(req_src1, op_is_signed(w_req_op));
          r_din2      <= encode_operand(req_src2, op_is_signed(w_req_op));
          r_reuse_vld <= 1'b0;
        end
      end
      if (flush && (r_state == ST_ISSUE || r_state == ST_WAIT_RDY)) r_killed <= 1'b1;
      if (w_div_done && !w_kill) begin
        r_quot      <= div_quotient;
        r_rem       <= div_remainder;
        r_reuse_vld <= 1'b1;
        r_resp_data <= op_is_rem(r_op) ? div_remainder : div_quotient;
      end
      if (r_state == ST_REUSE) r_resp_data <= op_is_rem(r_op) ? r_rem : r_quot;
      if (flush) r_reuse_vld <= 1'b0;
    end
  end

  assign resp_data     = r_resp_data;
  assign div_din1      = r_din1;
  assign div_din2      = r_din2;
  assign div_data_done = r_data_done;

endmodule

// File: tb/tb_ycr_pipe_div_ctrl.sv
// Scoreboard bench: two controllers (reuse off / on) share one behavioural divider.
module tb_ycr_pipe_div_ctrl;
  import ycr_pipe_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, flush = 1'b0, resp_ready = 1'b1, div_rdy = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_src1 = '0, req_src2 = '0, div_quotient = '0, div_remainder = '0;

  logic        d_req_ready  [2];
  logic        d_resp_valid [2];
  logic [31:0] d_resp_data  [2];
  logic        d_dv         [2];
  logic [32:0] d_din1       [2];
  logic [32:0] d_din2       [2];
  logic        d_done       [2];

  wire         m_req_ready  = d_req_ready[sel];
  wire         m_resp_valid = d_resp_valid[sel];
  wire  [31:0] m_resp_data  = d_resp_data[sel];
  wire         m_dv         = d_dv[sel];
  wire  [32:0] m_din1       = d_din1[sel];
  wire  [32:0] m_din2       = d_din2[sel];
  wire         m_done       = d_done[sel];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          dv_count = 0;
  int          done_spurious = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  ycr_pipe_div_ctrl #(.REUSE_EN(1'b0)) u_dut_noreuse (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(d_req_ready[0]),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .flush(flush && !sel),
    .resp_valid(d_resp_valid[0]), .resp_ready(resp_ready), .resp_data(d_resp_data[0]),
    .div_data_valid(d_dv[0]), .div_din1(d_din1[0]), .div_din2(d_din2[0]),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_rdy(div_rdy && !sel), .div_data_done(d_done[0]));

  ycr_pipe_div_ctrl #(.REUSE_EN(1'b1)) u_dut_reuse (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(d_req_ready[1]),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .flush(flush && sel),
    .resp_valid(d_resp_valid[1]), .resp_ready(resp_ready), .resp_data(d_resp_data[1]),
    .div_data_valid(d_dv[1]), .div_din1(d_din1[1]), .div_din2(d_din2[1]),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_rdy(div_rdy && sel), .div_data_done(d_done[1]));

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input bit expect_resp);
    check("req_ready_before_send", 33'(m_req_ready), 33'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    if (expect_resp) exp_q.push_back(exp);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(posedge clk); #1;
      ok = (exp_q.size() == 0) && m_req_ready;
    end
    check(name, 33'(ok), 33'd1);
  endtask

  // Behavioural divider: 18-cycle latency, re-reads the operands in its last stage.
  initial begin : divider_model
    logic signed [32:0] a, b, q, r;
    logic [32:0]        snap1, snap2;
    forever begin
      @(negedge clk);
      div_rdy = 1'b0;
      if (m_done) done_spurious++;
      if (m_dv && !rst) begin
        dv_count++;
        snap1 = m_din1;
        snap2 = m_din2;
        @(negedge clk);
        check("dv_single_cycle", 33'(m_dv), 33'd0);
        for (int i = 0; i < 17; i++) begin
          if (m_done) done_spurious++;
          @(negedge clk);
        end
        check("din1_held", m_din1, snap1);
        check("din2_held", m_din2, snap2);
        a = $signed(m_din1);
        b = $signed(m_din2);
        if (b == 0) begin
          div_quotient  = '1;
          div_remainder = m_din1[31:0];
        end else begin
          q = a / b;
          r = a % b;
          div_quotient  = q[31:0];
          div_remainder = r[31:0];
        end
        div_rdy = 1'b1;
        @(negedge clk);
        div_rdy = 1'b0;
        check("data_done_after_rdy", 33'(m_done), 33'd1);
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && m_resp_valid && resp_ready) begin
        if (exp_q.size() == 0) check("resp_unexpected", 33'(m_resp_valid), 33'd0);
        else                   check("resp_data", 33'(m_resp_data), 33'(exp_q.pop_front()));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    int dv0;
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_req_ready",  33'(m_req_ready),  33'd1);
    check("rst_resp_valid", 33'(m_resp_valid), 33'd0);
    check("rst_resp_data",  33'(m_resp_data),  33'd0);
    check("rst_div_valid",  33'(m_dv),         33'd0);
    check("rst_din1",       m_din1,            33'd0);
    check("rst_din2",       m_din2,            33'd0);
    check("rst_data_done",  33'(m_done),       33'd0);
    check("rst_req_ready1", 33'(d_req_ready[1]), 33'd1);

    // Reuse disabled: both ops of a pair go to the divider.
    dv0 = dv_count;
    send(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1); wait_done("done_divu");
    send(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b1);  wait_done("done_remu");
    check("noreuse_dv_count", 33'(dv_count - dv0), 33'd2);

    send(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
    check("din1_signed", m_din1, 33'h1_FFFF_FFF9);
    check("din2_signed", m_din2, 33'h0_0000_0002);
    wait_done("done_div_neg");
    send(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1); wait_done("done_rem_neg");

    send(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1); wait_done("done_div_zero");
    send(OP_REM, 32'd5, 32'd0, 32'd5, 1'b1);         wait_done("done_rem_zero");
    send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1); wait_done("done_div_ovf");
    send(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);         wait_done("done_rem_ovf");

    // Backpressure: response must hold while resp_ready is low.
    resp_ready = 1'b0;
    send(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    n = 0;
    while (!m_resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("bp_resp_arrives", 33'(m_resp_valid), 33'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("bp_resp_valid_held", 33'(m_resp_valid), 33'd1);
      check("bp_resp_data_held",  33'(m_resp_data),  33'd14);
      check("bp_req_ready_low",   33'(m_req_ready),  33'd0);
    end
    resp_ready = 1'b1;
    wait_done("done_backpressure");

    // Reuse enabled instance.
    sel = 1'b1;
    @(posedge clk); #1;
    dv0 = dv_count;
    send(OP_DIV, 32'd100, 32'd7, 32'd14, 1'b1); wait_done("done_reuse_div");
    check("reuse_first_uses_div", 33'(dv_count - dv0), 33'd1);
    dv0 = dv_count;
    send(OP_REM, 32'd100, 32'd7, 32'd2, 1'b1);
    n = 0;
    while (!m_resp_valid && n < 2) begin @(posedge clk); #1; n++; end
    check("reuse_resp_latency", 33'(m_resp_valid), 33'd1);
    wait_done("done_reuse_rem");
    check("reuse_no_div_traffic", 33'(dv_count - dv0), 33'd0);
    dv0 = dv_count;
    send(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1); wait_done("done_reuse_miss");
    check("reuse_miss_uses_div", 33'(dv_count - dv0), 33'd1);

    // Flush together with a request in IDLE: not accepted.
    dv0 = dv_count;
    req_valid = 1'b1; req_op = OP_DIVU; req_src1 = 32'd9; req_src2 = 32'd3; flush = 1'b1;
    #1 check("flush_blocks_ready", 33'(m_req_ready), 33'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("flush_idle_no_issue", 33'(dv_count - dv0), 33'd0);
    check("flush_idle_stays_idle", 33'(m_req_ready), 33'd1);

    // Kill an in-flight op; the next identical op must not reuse it.
    dv0 = dv_count;
    send(OP_DIVU, 32'd9, 32'd3, 32'd0, 1'b0);
    repeat (5) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_done("done_killed");
    send(OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b1); wait_done("done_after_kill");
    check("kill_no_reuse", 33'(dv_count - dv0), 33'd2);

    repeat (4) @(posedge clk);
    #1 check("queue_empty", 33'(exp_q.size()), 33'd0);
    check("data_done_spurious", 33'(done_spurious), 33'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
